// File: rtl/sender_pkg.sv
// Shared types and constants for the message-stream sender.
package sender_pkg;
  localparam int unsigned LEAF_W = 128;

  typedef enum logic {RAW = 1'b0, CORR = 1'b1} stream_mode_t;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} stream_state_t;
endpackage

// File: rtl/sender_word_buffer.sv
// Active/shadow leaf-word pair; swap forwards incoming data when it coincides with a shadow load.
module sender_word_buffer
  import sender_pkg::*;
#(
  parameter int unsigned LANES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load_active,
  input  logic                    i_load_shadow,
  input  logic                    i_swap,
  input  logic [LANES*LEAF_W-1:0] i_data,
  output logic [LANES*LEAF_W-1:0] o_active
);
  logic [LANES*LEAF_W-1:0] r_active;
  logic [LANES*LEAF_W-1:0] r_shadow;
  logic [LANES*LEAF_W-1:0] w_shadow_fwd;

  assign w_shadow_fwd = i_load_shadow ? i_data : r_shadow;
  assign o_active     = r_active;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_active <= '0;
      r_shadow <= '0;
    end else begin
      if (i_load_active) begin
        r_active <= i_data;
      end else if (i_swap) begin
        r_active <= w_shadow_fwd;
      end
      if (i_load_shadow) begin
        r_shadow <= i_data;
      end
    end
  end
endmodule

// File: rtl/sender_msg_stream.sv
// Streams LANES*2**D leaf messages from a leaf RAM, prefetching the next word while
// the current one drains so a continuously ready consumer sees one message per cycle.
module sender_msg_stream
  import sender_pkg::*;
#(
  parameter int unsigned D     = 3,
  parameter int unsigned LANES = 8,
  parameter int unsigned IDX_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    func,
  input  logic [LEAF_W-1:0]       delta,
  input  logic [IDX_W-1:0]        msg_index,
  output logic                    rd_en,
  output logic [D-1:0]            rd_addr,
  input  logic [LANES*LEAF_W-1:0] rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LEAF_W-1:0]       out_m0,
  output logic [LEAF_W-1:0]       out_m1,
  output logic [IDX_W-1:0]        out_index,
  output logic                    done
);
  localparam int unsigned WORDS   = 2 ** D;
  localparam int unsigned OT_SIZE = LANES * WORDS;
  localparam int unsigned LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

  stream_state_t           r_state;
  stream_mode_t            r_func;
  logic [LEAF_W-1:0]       r_delta;
  logic [IDX_W-1:0]        r_index;
  logic [LANE_W-1:0]       r_lane;
  logic [D-1:0]            r_word;
  logic                    r_rd_en;
  logic                    r_rd_vld;
  logic [D-1:0]            r_rd_addr;
  logic                    r_out_valid;
  logic                    r_done;

  logic [LANES*LEAF_W-1:0] w_active;
  logic [LEAF_W-1:0]       w_leaf;
  logic                    w_xfer;
  logic                    w_last_lane;
  logic                    w_last_word;
  logic [D-1:0]            w_next_word;
  logic                    w_load_active;
  logic                    w_load_shadow;
  logic                    w_swap;

  assign w_xfer        = r_out_valid && out_ready;
  assign w_last_lane   = (r_lane == LANE_W'(LANES - 1));
  assign w_last_word   = (r_word == D'(WORDS - 1));
  assign w_next_word   = r_word + D'(1);
  // r_rd_vld marks the cycle rd_data carries the word requested one cycle earlier.
  assign w_load_active = (r_state == FILL) && r_rd_vld;
  assign w_load_shadow = (r_state == STREAM) && r_rd_vld;
  assign w_swap        = (r_state == STREAM) && w_xfer && w_last_lane && !w_last_word;

  sender_word_buffer #(
    .LANES (LANES)
  ) u_buf (
    .clk           (clk),
    .rst           (rst),
    .i_load_active (w_load_active),
    .i_load_shadow (w_load_shadow),
    .i_swap        (w_swap),
    .i_data        (rd_data),
    .o_active      (w_active)
  );

  assign w_leaf    = w_active[r_lane*LEAF_W +: LEAF_W];
  assign out_m0    = w_leaf;
  assign out_m1    = (r_func == CORR) ? (w_leaf ^ r_delta) : '0;
  assign out_index = r_index;
  assign out_valid = r_out_valid;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_func      <= RAW;
      r_delta     <= '0;
      r_index     <= '0;
      r_lane      <= '0;
      r_word      <= '0;
      r_rd_en     <= 1'b0;
      r_rd_vld    <= 1'b0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_en  <= 1'b0;
      r_rd_vld <= r_rd_en;
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_func    <= stream_mode_t'(func);
            r_delta   <= delta;
            r_index   <= msg_index;
            r_lane    <= '0;
            r_word    <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (r_rd_vld) begin
            r_out_valid <= 1'b1;
            r_state     <= STREAM;
            if (WORDS > 1) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= D'(1);
            end
          end
        end
        STREAM: begin
          if (w_xfer) begin
            r_index <= r_index + IDX_W'(1);
            if (!w_last_lane) begin
              r_lane <= r_lane + LANE_W'(1);
            end else begin
              r_lane <= '0;
              if (w_last_word) begin
                r_out_valid <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= DONE;
              end else begin
                r_word <= w_next_word;
                // Prefetch the word after the one being entered, if there is one.
                if (w_next_word != D'(WORDS - 1)) begin
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= w_next_word + D'(1);
                end
              end
            end
          end
        end
        DONE: begin
          if (!enable) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // OT_SIZE documents the run length; the counters above encode it structurally.
  logic [31:0] w_ot_size_unused;
  assign w_ot_size_unused = 32'(OT_SIZE);
endmodule

// File: tb/tb_sender_msg_stream.sv
// Scoreboard bench for sender_msg_stream: expected messages queued per run, monitor compares.
module tb_sender_msg_stream;
  import sender_pkg::*;

  localparam int D     = 3;
  localparam int LANES = 8;
  localparam int IDX_W = 32;
  localparam int WORDS = 8;
  localparam int OT    = 64;
  localparam logic [127:0] DELTA = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    enable = 1'b0;
  logic                    func = 1'b0;
  logic [127:0]            delta = '0;
  logic [IDX_W-1:0]        msg_index = '0;
  logic                    rd_en;
  logic [D-1:0]            rd_addr;
  logic [LANES*128-1:0]    rd_data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [127:0]            out_m0;
  logic [127:0]            out_m1;
  logic [IDX_W-1:0]        out_index;
  logic                    done;

  typedef struct packed {
    logic [127:0]     m0;
    logic [127:0]     m1;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   xfer_cnt = 0;
  int   rd_cnt = 0;
  int   dup_cnt = 0;
  bit   rd_seen[WORDS];
  bit   rand_ready = 1'b0;

  sender_msg_stream #(
    .D     (D),
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .func      (func),
    .delta     (delta),
    .msg_index (msg_index),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_m0    (out_m0),
    .out_m1    (out_m1),
    .out_index (out_index),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] leaf(input int w, input int k);
    return {32'(w), 32'(k), 32'hCAFEF00D, 32'(w * LANES + k)};
  endfunction

  function automatic logic [LANES*128-1:0] mkword(input int w);
    logic [LANES*128-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*128 +: 128] = leaf(w, k);
    return r;
  endfunction

  // Leaf RAM: one-cycle read latency, junk on idle cycles.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mkword(int'(rd_addr));
    else       rd_data <= {LANES{128'hDEADBEEF_0BADF00D_DEADBEEF_0BADF00D}};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every valid cycle must match the queue head; head pops on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_en) begin
        rd_cnt++;
        if (rd_seen[rd_addr]) dup_cnt++;
        rd_seen[rd_addr] = 1'b1;
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got index %0h expected no message", out_index);
        end else begin
          if ({out_m0, out_m1, out_index} !== {q[0].m0, q[0].m1, q[0].idx}) begin
            errors++;
            $display("FAIL message: got m0=%h m1=%h idx=%h expected m0=%h m1=%h idx=%h",
                     out_m0, out_m1, out_index, q[0].m0, q[0].m1, q[0].idx);
          end
          if (out_ready) begin
            void'(q.pop_front());
            xfer_cnt++;
          end
        end
      end
    end
  end

  task automatic start_run(input logic f, input logic [127:0] dl, input logic [IDX_W-1:0] base,
                           input bit hold);
    exp_t e;
    q.delete();
    rd_cnt   = 0;
    dup_cnt  = 0;
    xfer_cnt = 0;
    for (int i = 0; i < WORDS; i++) rd_seen[i] = 1'b0;
    for (int w = 0; w < WORDS; w++) begin
      for (int k = 0; k < LANES; k++) begin
        e.m0  = leaf(w, k);
        e.m1  = f ? (leaf(w, k) ^ dl) : '0;
        e.idx = base + IDX_W'(w * LANES + k);
        q.push_back(e);
      end
    end
    @(negedge clk);
    func      = f;
    delta     = dl;
    msg_index = base;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after the start edge; the DUT must use its latched copies.
    func      = ~f;
    delta     = ~dl;
    msg_index = ~base;
    if (!hold) enable = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int first_valid);
    cyc = 0;
    first_valid = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) break;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic post_run(input int exp_cyc, input int cyc, input int first_valid);
    chk("first_valid_latency", first_valid, 2);
    if (exp_cyc > 0) chk("done_latency", cyc, exp_cyc);
    chk("valid_low_at_done", out_valid, 0);
    chk("queue_drained", q.size(), 0);
    chk("transfers", xfer_cnt, OT);
    chk("read_count", rd_cnt, WORDS);
    chk("read_dup", dup_cnt, 0);
  endtask

  initial begin
    int cyc;
    int fv;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_m0", out_m0, 0);
    chk("rst_out_m1", out_m1, 0);
    @(negedge clk);
    rst = 1'b1;

    // CORR, continuous ready
    start_run(1'b1, DELTA, 32'h0, 1'b0);
    wait_done(cyc, fv);
    post_run(66, cyc, fv);
    @(posedge clk); #1;
    chk("idle_done_low", done, 0);

    // RAW, continuous ready
    start_run(1'b0, DELTA, 32'h0, 1'b0);
    wait_done(cyc, fv);
    post_run(66, cyc, fv);
    @(posedge clk); #1;

    // CORR, random ready
    rand_ready = 1'b1;
    start_run(1'b1, DELTA, 32'h0, 1'b0);
    wait_done(cyc, fv);
    post_run(0, cyc, fv);
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // index wrap
    start_run(1'b1, DELTA, 32'hFFFF_FFF0, 1'b0);
    wait_done(cyc, fv);
    post_run(66, cyc, fv);
    chk("wrap_final_index", out_index, 32'h0000_0030);
    @(posedge clk); #1;

    // reset at message 20
    start_run(1'b1, DELTA, 32'h0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (xfer_cnt >= 20) break;
    end
    chk("xfers_before_reset", xfer_cnt, 20);
    rst = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_out_index", out_index, 0);
    chk("midrst_out_m0", out_m0, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("no_valid_after_reset", out_valid, 0);
    end
    start_run(1'b1, DELTA, 32'h0000_0100, 1'b0);
    wait_done(cyc, fv);
    post_run(66, cyc, fv);
    @(posedge clk); #1;

    // hold enable after done
    start_run(1'b0, DELTA, 32'h0000_0005, 1'b1);
    wait_done(cyc, fv);
    post_run(66, cyc, fv);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("done_held", done, 1);
      chk("valid_low_held", out_valid, 0);
    end
    chk("no_reads_while_held", rd_cnt, WORDS);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("done_cleared", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("stays_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
